// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and the {sum, conv} result-pair type for the convolution result path
package conv_pkg;
  localparam int CONV_DW = 8;
  localparam int RES_FIFO_DEPTH = 8;
  localparam int RES_FIFO_AW = 3;
  typedef struct packed {
    logic [CONV_DW-1:0] sum;
    logic [CONV_DW-1:0] conv;
  } conv_res_t;
endpackage

// File: rtl/conv_res_mem.sv
// conv_res_mem: DEPTH x W register array; sync write (we/waddr/wdata), async read (raddr/rdata), no reset
module conv_res_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge CLK) if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/conv_result_fifo.sv
// conv_result_fifo: FWFT FIFO of {conv,sum} pairs; in_valid/in_ready in, out_valid/out_ready out, count/full/empty status, saturating drop_cnt, sync clear
module conv_result_fifo
  import conv_pkg::*;
#(
  parameter int DW    = CONV_DW,
  parameter int DEPTH = RES_FIFO_DEPTH,
  parameter int AW    = RES_FIFO_AW
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_conv,
  input  logic [DW-1:0] in_sum,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_conv,
  output logic [DW-1:0] out_sum,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [7:0]    drop_cnt
);
  logic [AW-1:0]   r_wr, r_rd;
  logic [AW:0]     r_cnt;
  logic [7:0]      r_drop;
  logic            w_push, w_pop, w_drop;
  logic [2*DW-1:0] w_rdata;
  assign full      = r_cnt == (AW+1)'(DEPTH);
  assign empty     = r_cnt == '0;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign w_push    = in_valid && in_ready && !clear;
  assign w_pop     = out_valid && out_ready && !clear;
  assign w_drop    = in_valid && !in_ready;
  assign count     = r_cnt;
  assign drop_cnt  = r_drop;
  assign {out_sum, out_conv} = w_rdata;
  conv_res_mem #(.W(2*DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .CLK  (CLK),
    .we   (w_push),
    .waddr(r_wr),
    .wdata({in_sum, in_conv}),
    .raddr(r_rd),
    .rdata(w_rdata)
  );
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn || clear) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push != w_pop) r_cnt <= w_push ? r_cnt + 1'b1 : r_cnt - 1'b1;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
    end
  end
endmodule

// File: doc/conv_result_fifo.md
Name: conv_result_fifo

Overview:
Buffers the convolution engine's per-sample results (CONV_OUT and sumout) so a slower consumer can drain them. Sits directly downstream of the convolution stage. Results are stored as {conv, sum} pairs in a small first-word-fall-through FIFO with a valid/ready output handshake. Overflow drops are counted, never silently lost.

Parameters:
DW, 8, width of each result field (conv and sum)
DEPTH, 8, number of result pairs stored; power of two, at least 2
AW, 3, pointer width, equal to log2(DEPTH)

Ports:
CLK  input  1  system clock, rising-edge active
RSTn  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of FIFO contents and drop counter
in_valid  input  1  upstream result pair present this cycle
in_conv  input  DW  convolution result (from CONV_OUT)
in_sum  input  DW  running sum (from sumout)
in_ready  output  1  FIFO can accept a pair this cycle
out_valid  output  1  head pair available
out_conv  output  DW  head conv value
out_sum  output  DW  head sum value
out_ready  input  1  consumer takes the head pair this cycle
count  output  AW+1  occupancy, 0 to DEPTH
full  output  1  count equals DEPTH
empty  output  1  count equals 0
drop_cnt  output  8  number of pairs offered while full; saturates at 255

Behaviour:
- Clock and reset: one clock, CLK; reset RSTn is asynchronous and active-low.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, drop_cnt=0, so empty=1, full=0, out_valid=0, in_ready=1. out_conv and out_sum are don't-care while out_valid=0. Storage contents are not reset.
- Handshake signals:
  - in_ready = !full, decoded from registered count only; no pop-through-when-full.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = !empty.
  - out_conv and out_sum read combinationally from mem[rd_ptr].
- Latency:
  - A pair pushed at edge N is visible on out_* with out_valid=1 in the cycle after edge N.
  - No same-cycle bypass from input to output.
- Pointers: wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop in the same cycle (legal whenever 0 < count < DEPTH).
- Empty boundary: pop is impossible (out_valid=0). A push in that cycle is accepted and count becomes 1.
- Full boundary:
  - in_ready=0, so a simultaneous in_valid is a drop, even if out_ready=1 in the same cycle.
  - The pop still occurs, so count becomes DEPTH-1.
- drop_cnt: increments on every cycle with in_valid & !in_ready; holds at 255.
- clear:
  - Synchronous; highest priority over push and pop.
  - Next cycle: pointers=0, count=0, drop_cnt=0.
  - A push coincident with clear is discarded and not counted as a drop.
- Reset mid-operation: RSTn low immediately forces the reset values, regardless of any handshake in progress.
- Status: full and empty are decoded from the registered count (glitch-free, no combinational path from inputs).
- Occupancy state machine, implicit in count:
  - EMPTY (count=0) -> PARTIAL on push.
  - PARTIAL -> FULL when count reaches DEPTH.
  - PARTIAL -> EMPTY when count reaches 0.
  - FULL -> PARTIAL on pop.
  - Any state -> EMPTY on clear.

Decomposition:
- Shared package conv_pkg holds: CONV_DW=8, RES_FIFO_DEPTH=8, RES_FIFO_AW=3, and a packed pair type conv_res_t = {sum, conv} (2*DW bits).
- One sub-module: conv_res_mem. It is a DEPTH x 2*DW register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata), with no reset.
- Pointer, count, drop and handshake logic stay in conv_result_fifo.

Test Plan:
1. Reset then idle: RSTn low for 50 ns, then high, with no in_valid -> empty=1, out_valid=0, in_ready=1, count=0, drop_cnt=0.
2. Single pass-through: push (conv=0x12, sum=0x34) with out_ready=0 -> next cycle out_valid=1, out_conv=0x12, out_sum=0x34, count=1. Then raise out_ready for one cycle -> empty=1.
3. Fill and overflow: push 0x01..0x0A on consecutive cycles with out_ready=0 -> full=1 after 8 pushes, drop_cnt=2. Drain yields 0x01..0x08 in order.
4. Simultaneous push/pop:
   - At count=4, assert in_valid and out_ready for 20 cycles -> count stays 4, outputs remain in order, pointers wrap with no corruption.
   - At full, assert in_valid=1 and out_ready=1 -> head popped, count=7, drop_cnt+1.
5. Clear priority: at count=5 and drop_cnt=3, assert clear with in_valid=1 -> next cycle count=0, drop_cnt=0, out_valid=0, and the pushed pair is absent.
6. Reset mid-stream: assert RSTn low while count=6 and out_ready=1 -> outputs take reset values immediately, without waiting for a clock edge. After release, the first new push appears as the head.
